// File: rtl/bru_pkg.sv
// ---------------------------------------------------------------------------
// bru_pkg
// Shared types for the branch reservation station.
//   XLEN / TAG_W   : operand/PC width and ROB tag width (fixed for the slice)
//   br_op_e        : branch opcodes (3-bit encoding, value 7 is undefined)
//   TAG_INVALID    : all-ones tag, meaning "operand value present"
//   brs_entry_t    : one station slot
// Configuration macro: BRU_JALR_EN (enables the JALR opcode).
// ---------------------------------------------------------------------------
package bru_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  // Age counter width: ages are kept as a dense 0..DEPTH-1 ranking, so
  // 8 bits covers any DEPTH up to 256.
  localparam int AGE_W = 8;

  localparam logic [TAG_W-1:0] TAG_INVALID = '1;

`ifdef BRU_JALR_EN
  localparam bit JALR_EN = 1'b1;
`else
  localparam bit JALR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd2,
    BGE  = 3'd3,
    BLTU = 3'd4,
    BGEU = 3'd5,
    JALR = 3'd6
  } br_op_e;

  // tag[0]/val[0] hold source 1, tag[1]/val[1] hold source 2.
  typedef struct packed {
    logic                  valid;
    logic [AGE_W-1:0]      age;
    logic [TAG_W-1:0]      target;
    br_op_e                op;
    logic [1:0][TAG_W-1:0] tag;
    logic [1:0][XLEN-1:0]  val;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       offset;
  } brs_entry_t;

  // JALR only consumes source 1, so its source 2 never blocks issue.
  function automatic logic src2_needed(br_op_e op);
    return !(JALR_EN && (op == JALR));
  endfunction

endpackage

// File: rtl/branch_resv_station_if.sv
// ---------------------------------------------------------------------------
// branch_resv_station_if
// Bundles dispatch-side allocation, CDB snoop and resolve outputs.
//   master : dispatch/CDB driver (drives flush, alloc_*, cdb_*)
//   slave  : the station (drives alloc_ready, res_*)
// alloc_tag/alloc_val index [0] = source 1, [1] = source 2.
// ---------------------------------------------------------------------------
interface branch_resv_station_if #(
  parameter int CDB_PORTS = 2
);
  import bru_pkg::*;

  logic                               flush;
  logic                               alloc_valid;
  logic                               alloc_ready;
  logic [TAG_W-1:0]                   alloc_target;
  logic [2:0]                         alloc_op;
  logic [1:0][TAG_W-1:0]              alloc_tag;
  logic [1:0][XLEN-1:0]               alloc_val;
  logic [XLEN-1:0]                    alloc_pc;
  logic [XLEN-1:0]                    alloc_offset;
  logic [CDB_PORTS-1:0]               cdb_valid;
  logic [CDB_PORTS-1:0][TAG_W-1:0]    cdb_tag;
  logic [CDB_PORTS-1:0][XLEN-1:0]     cdb_val;
  logic                               res_valid;
  logic [TAG_W-1:0]                   res_target;
  logic                               res_taken;
  logic [XLEN-1:0]                    res_next_pc;

  modport master (
    output flush, alloc_valid, alloc_target, alloc_op, alloc_tag, alloc_val,
           alloc_pc, alloc_offset, cdb_valid, cdb_tag, cdb_val,
    input  alloc_ready, res_valid, res_target, res_taken, res_next_pc
  );

  modport slave (
    input  flush, alloc_valid, alloc_target, alloc_op, alloc_tag, alloc_val,
           alloc_pc, alloc_offset, cdb_valid, cdb_tag, cdb_val,
    output alloc_ready, res_valid, res_target, res_taken, res_next_pc
  );
endinterface

// File: rtl/bru_compare.sv
// ---------------------------------------------------------------------------
// bru_compare
// Combinational branch resolver.
//   i_op      : branch opcode
//   i_val1/2  : source operands
//   i_pc      : branch PC
//   i_offset  : sign-extended immediate
//   o_taken   : compare outcome
//   o_next_pc : taken ? pc+offset : pc+4 (JALR: (val1+offset) & ~1)
// Configuration macro: BRU_JALR_EN (via bru_pkg::JALR_EN).
// ---------------------------------------------------------------------------
module bru_compare
  import bru_pkg::*;
(
  input  br_op_e          i_op,
  input  logic [XLEN-1:0] i_val1,
  input  logic [XLEN-1:0] i_val2,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_offset,
  output logic            o_taken,
  output logic [XLEN-1:0] o_next_pc
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    o_taken   = 1'b0;
    o_next_pc = i_pc + XLEN'(4);
    case (i_op)
      BEQ:     o_taken = (i_val1 == i_val2);
      BNE:     o_taken = (i_val1 != i_val2);
      BLT:     o_taken = ($signed(i_val1) <  $signed(i_val2));
      BGE:     o_taken = ($signed(i_val1) >= $signed(i_val2));
      BLTU:    o_taken = (i_val1 <  i_val2);
      BGEU:    o_taken = (i_val1 >= i_val2);
      default: o_taken = 1'b0;
    endcase
    if (o_taken) o_next_pc = i_pc + i_offset;
    if (JALR_EN && (i_op == JALR)) begin
      o_taken   = 1'b1;
      o_next_pc = (i_val1 + i_offset) & ~XLEN'(1);
    end
  end

endmodule

// File: rtl/branch_resv_station.sv
// ---------------------------------------------------------------------------
// branch_resv_station
// DEPTH-entry branch reservation station with integrated resolver.
// Buffers branches from dispatch, snoops CDB_PORTS broadcast ports for
// pending operands and issues the oldest ready entry each cycle, producing a
// registered one-cycle result pulse.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : branch_resv_station_if.slave (flush, alloc_*, cdb_*, res_*)
// Configuration macro: BRU_JALR_EN (JALR accepted, ready on source 1 only).
// ---------------------------------------------------------------------------
module branch_resv_station
  import bru_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int CDB_PORTS = 2
) (
  input logic                   clk,
  input logic                   rst,
  branch_resv_station_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  brs_entry_t       r_entry     [DEPTH];
  brs_entry_t       w_entry_nxt [DEPTH];
  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_ready;
  logic             w_full;
  logic             w_insert;
  logic             w_issue;
  logic [IDX_W-1:0] w_free_idx;
  logic [IDX_W-1:0] w_issue_idx;
  logic [AGE_W-1:0] w_issue_age;
  logic             w_taken;
  logic [XLEN-1:0]  w_next_pc;

  logic             r_res_valid;
  logic [TAG_W-1:0] r_res_target;
  logic             r_res_taken;
  logic [XLEN-1:0]  r_res_next_pc;

  // Capture a broadcast value for a pending tag. Ports are scanned downwards
  // so the lowest matching port is written last and wins.
  function automatic logic [TAG_W+XLEN-1:0] snoop(
    input logic [TAG_W-1:0]                 tag,
    input logic [XLEN-1:0]                  val,
    input logic [CDB_PORTS-1:0]             cv,
    input logic [CDB_PORTS-1:0][TAG_W-1:0]  ct,
    input logic [CDB_PORTS-1:0][XLEN-1:0]   cval
  );
    logic [TAG_W-1:0] t = tag;
    logic [XLEN-1:0]  v = val;
    if (tag != TAG_INVALID) begin
      for (int p = CDB_PORTS - 1; p >= 0; p--) begin
        if (cv[p] && (ct[p] == tag)) begin
          t = TAG_INVALID;
          v = cval[p];
        end
      end
    end
    return {t, v};
  endfunction

  // Readiness, free-slot and oldest-ready selection, all from current state
  // so a slot freed this cycle is only visible next cycle.
  always_comb begin
    w_valid     = '0;
    w_ready     = '0;
    w_free_idx  = '0;
    w_issue     = 1'b0;
    w_issue_idx = '0;
    w_issue_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = r_entry[i].valid;
      w_ready[i] = r_entry[i].valid && (r_entry[i].tag[0] == TAG_INVALID) &&
                   ((r_entry[i].tag[1] == TAG_INVALID) || !src2_needed(r_entry[i].op));
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!w_valid[i]) w_free_idx = IDX_W'(i);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ready[i] && (!w_issue || (r_entry[i].age > w_issue_age))) begin
        w_issue     = 1'b1;
        w_issue_idx = IDX_W'(i);
        w_issue_age = r_entry[i].age;
      end
    end
    w_full   = &w_valid;
    w_insert = bus.alloc_valid && !w_full;
  end

  // Next state of every slot. Ages are a dense ranking: an insert pushes
  // every survivor one step older, and an issue closes the gap it leaves,
  // so ages stay unique and bounded by DEPTH-1.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      // NOTE: blocking assignments here build the value step by step within
      // one evaluation; registered state only ever takes <= in always_ff.
      w_entry_nxt[i] = r_entry[i];
      if (r_entry[i].valid) begin
        for (int s = 0; s < 2; s++) begin
          {w_entry_nxt[i].tag[s], w_entry_nxt[i].val[s]} =
            snoop(r_entry[i].tag[s], r_entry[i].val[s],
                  bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
        end
        if (w_insert) w_entry_nxt[i].age = w_entry_nxt[i].age + AGE_W'(1);
        if (w_issue && (r_entry[i].age > w_issue_age))
          w_entry_nxt[i].age = w_entry_nxt[i].age - AGE_W'(1);
        if (w_issue && (w_issue_idx == IDX_W'(i))) w_entry_nxt[i].valid = 1'b0;
      end
      if (w_insert && (w_free_idx == IDX_W'(i))) begin
        w_entry_nxt[i].valid  = 1'b1;
        w_entry_nxt[i].age    = '0;
        w_entry_nxt[i].target = bus.alloc_target;
        w_entry_nxt[i].op     = br_op_e'(bus.alloc_op);
        w_entry_nxt[i].pc     = bus.alloc_pc;
        w_entry_nxt[i].offset = bus.alloc_offset;
        for (int s = 0; s < 2; s++) begin
          {w_entry_nxt[i].tag[s], w_entry_nxt[i].val[s]} =
            snoop(bus.alloc_tag[s], bus.alloc_val[s],
                  bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
        end
      end
    end
  end

  bru_compare u_compare (
    .i_op      (r_entry[w_issue_idx].op),
    .i_val1    (r_entry[w_issue_idx].val[0]),
    .i_val2    (r_entry[w_issue_idx].val[1]),
    .i_pc      (r_entry[w_issue_idx].pc),
    .i_offset  (r_entry[w_issue_idx].offset),
    .o_taken   (w_taken),
    .o_next_pc (w_next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the whole entry array is reset, not just the valid bits, so no
      // X payload can ever reach the issue mux or the resolver.
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
      r_res_valid   <= 1'b0;
      r_res_target  <= TAG_INVALID;
      r_res_taken   <= 1'b0;
      r_res_next_pc <= '0;
    end else if (bus.flush) begin
      // Flush wins over both insert and issue in the same cycle.
      for (int i = 0; i < DEPTH; i++) r_entry[i].valid <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_target <= TAG_INVALID;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= w_entry_nxt[i];
      r_res_valid  <= w_issue;
      r_res_target <= w_issue ? r_entry[w_issue_idx].target : TAG_INVALID;
      if (w_issue) begin
        r_res_taken   <= w_taken;
        r_res_next_pc <= w_next_pc;
      end
    end
  end

  assign bus.alloc_ready = !w_full;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_target  = r_res_target;
  assign bus.res_taken   = r_res_taken;
  assign bus.res_next_pc = r_res_next_pc;

endmodule

// File: tb/tb_branch_resv_station.sv
// ---------------------------------------------------------------------------
// tb_branch_resv_station
// Directed scenarios plus a randomized run against an insertion-ordered
// queue model of the station.
// ---------------------------------------------------------------------------
module tb_branch_resv_station;
  import bru_pkg::*;

  localparam int DEPTH = 4;
  localparam int CDB   = 2;
  localparam logic [3:0] TI = 4'hF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resv_station_if #(.CDB_PORTS(CDB)) bus ();
  branch_resv_station #(.DEPTH(DEPTH), .CDB_PORTS(CDB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]       target;
    logic [2:0]       op;
    logic [1:0][3:0]  tag;
    logic [1:0][31:0] val;
    logic [31:0]      pc;
    logic [31:0]      off;
  } m_ent_t;

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush = 1'b0; bus.alloc_valid = 1'b0; bus.alloc_target = '0;
    bus.alloc_op = '0; bus.alloc_tag = {TI, TI}; bus.alloc_val = '0;
    bus.alloc_pc = '0; bus.alloc_offset = '0;
    bus.cdb_valid = '0; bus.cdb_tag = '0; bus.cdb_val = '0;
  endtask

  task automatic alloc(input logic [3:0] tgt, input logic [2:0] op,
                       input logic [3:0] t1, input logic [3:0] t2,
                       input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] pc, input logic [31:0] off);
    bus.alloc_valid = 1'b1; bus.alloc_target = tgt; bus.alloc_op = op;
    bus.alloc_tag[0] = t1; bus.alloc_tag[1] = t2;
    bus.alloc_val[0] = v1; bus.alloc_val[1] = v2;
    bus.alloc_pc = pc; bus.alloc_offset = off;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_ready(input m_ent_t e);
    bit ok2 = (e.tag[1] == TI);
`ifdef BRU_JALR_EN
    if (e.op == 3'd6) ok2 = 1'b1;
`endif
    return (e.tag[0] == TI) && ok2;
  endfunction

  task automatic m_resolve(input m_ent_t e, output bit tk, output logic [31:0] npc);
    logic [31:0] a = e.val[0];
    logic [31:0] b = e.val[1];
    case (e.op)
      3'd0: tk = (a == b);
      3'd1: tk = (a != b);
      3'd2: tk = ($signed(a) <  $signed(b));
      3'd3: tk = ($signed(a) >= $signed(b));
      3'd4: tk = (a <  b);
      3'd5: tk = (a >= b);
      default: tk = 1'b0;
    endcase
    npc = tk ? e.pc + e.off : e.pc + 32'd4;
`ifdef BRU_JALR_EN
    if (e.op == 3'd6) begin tk = 1'b1; npc = (a + e.off) & 32'hFFFF_FFFE; end
`endif
  endtask

  function automatic m_ent_t m_wake(input m_ent_t e);
    m_ent_t r = e;
    for (int s = 0; s < 2; s++) begin
      if (r.tag[s] != TI) begin
        for (int p = 0; p < CDB; p++) begin
          if (bus.cdb_valid[p] && bus.cdb_tag[p] == r.tag[s]) begin
            r.val[s] = bus.cdb_val[p];
            r.tag[s] = TI;
            break;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [3:0] rand_tag();
    return ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : TI;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    alloc(4'd1, BEQ, 4'd5, TI, 32'd0, 32'd0, 32'h10, 32'd4); tick();
    alloc(4'd2, BNE, 4'd5, TI, 32'd0, 32'd0, 32'h20, 32'd4); tick();
    alloc(4'd3, BLT, TI, 4'd5, 32'd0, 32'd0, 32'h30, 32'd4); tick();
    alloc(4'd4, BEQ, TI, TI, 32'd1, 32'd1, 32'h200, 32'h10); tick();
    idle();
    n_checks++; if (bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pre_full got=%0b exp=0", bus.alloc_ready); end
    tick();
    n_checks++; if (bus.res_valid !== 1'b1 || bus.res_next_pc !== 32'h210) begin n_fail++; $display("FAIL rst_pre_result got=%0b/%h exp=1/00000210", bus.res_valid, bus.res_next_pc); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid got=%0b exp=0", bus.res_valid); end
    n_checks++; if (bus.res_target !== TI) begin n_fail++; $display("FAIL rst_res_target got=%h exp=f", bus.res_target); end
    n_checks++; if (bus.res_taken !== 1'b0) begin n_fail++; $display("FAIL rst_res_taken got=%0b exp=0", bus.res_taken); end
    n_checks++; if (bus.res_next_pc !== 32'd0) begin n_fail++; $display("FAIL rst_res_next_pc got=%h exp=0", bus.res_next_pc); end
    n_checks++; if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL rst_alloc_ready got=%0b exp=1", bus.alloc_ready); end
    rst = 1'b0;
    bus.cdb_valid = 2'b01; bus.cdb_tag[0] = 4'd5; bus.cdb_val[0] = 32'd0;
    tick(); idle(); tick(); tick();
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_entries_cleared got=%0b exp=0", bus.res_valid); end
  endtask

  task automatic test_beq();
    apply_reset();
    alloc(4'd7, BEQ, TI, TI, 32'd5, 32'd5, 32'h100, 32'h20); tick(); idle();
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL beq_early got=%0b exp=0", bus.res_valid); end
    tick();
    n_checks++; if (bus.res_valid !== 1'b1 || bus.res_target !== 4'd7) begin n_fail++; $display("FAIL beq_valid got=%0b/%h exp=1/7", bus.res_valid, bus.res_target); end
    n_checks++; if (bus.res_taken !== 1'b1 || bus.res_next_pc !== 32'h120) begin n_fail++; $display("FAIL beq_result got=%0b/%h exp=1/00000120", bus.res_taken, bus.res_next_pc); end
    tick();
    n_checks++; if (bus.res_valid !== 1'b0 || bus.res_target !== TI) begin n_fail++; $display("FAIL beq_pulse got=%0b/%h exp=0/f", bus.res_valid, bus.res_target); end
  endtask

  task automatic test_back_to_back_signed();
    apply_reset();
    alloc(4'd1, BLT,  TI, TI, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h40); tick();
    alloc(4'd2, BLTU, TI, TI, 32'hFFFF_FFFF, 32'd1, 32'h400, 32'h40); tick(); idle();
    n_checks++; if (bus.res_target !== 4'd1 || bus.res_taken !== 1'b1 || bus.res_next_pc !== 32'h340) begin n_fail++; $display("FAIL blt got=%h/%0b/%h exp=1/1/00000340", bus.res_target, bus.res_taken, bus.res_next_pc); end
    tick();
    n_checks++; if (bus.res_target !== 4'd2 || bus.res_taken !== 1'b0 || bus.res_next_pc !== 32'h404) begin n_fail++; $display("FAIL bltu got=%h/%0b/%h exp=2/0/00000404", bus.res_target, bus.res_taken, bus.res_next_pc); end
  endtask

  task automatic test_fill_wakeup();
    logic [31:0] exp_pc [4] = '{32'h1100, 32'h2004, 32'h3008, 32'h4004};
    logic        exp_tk [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    alloc(4'd1, BEQ,  4'd3, TI, 32'd0, 32'd7, 32'h1000, 32'h100); tick();
    alloc(4'd2, BNE,  4'd3, TI, 32'd0, 32'd7, 32'h2000, 32'h100); tick();
    alloc(4'd3, BLT,  4'd3, TI, 32'd0, 32'd8, 32'h3000, 32'h8);   tick();
    alloc(4'd4, BGEU, 4'd3, TI, 32'd0, 32'd8, 32'h4000, 32'h8);   tick();
    n_checks++; if (bus.alloc_ready !== 1'b0 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL fill_full got=%0b/%0b exp=0/0", bus.alloc_ready, bus.res_valid); end
    alloc(4'd5, BEQ, TI, TI, 32'd0, 32'd0, 32'h5000, 32'h4);
    bus.cdb_valid = 2'b11;
    bus.cdb_tag[0] = 4'd2; bus.cdb_val[0] = 32'd99;
    bus.cdb_tag[1] = 4'd3; bus.cdb_val[1] = 32'd7;
    tick(); idle();
    n_checks++; if (bus.res_valid !== 1'b0 || bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL fill_wake_cycle got=%0b/%0b exp=0/0", bus.res_valid, bus.alloc_ready); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (bus.res_valid !== 1'b1 || bus.res_target !== 4'(k + 1)) begin n_fail++; $display("FAIL fill_order_%0d got=%0b/%h exp=1/%0d", k, bus.res_valid, bus.res_target, k + 1); end
      n_checks++; if (bus.res_taken !== exp_tk[k] || bus.res_next_pc !== exp_pc[k]) begin n_fail++; $display("FAIL fill_result_%0d got=%0b/%h exp=%0b/%h", k, bus.res_taken, bus.res_next_pc, exp_tk[k], exp_pc[k]); end
    end
    n_checks++; if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_after got=%0b exp=1", bus.alloc_ready); end
    tick();
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL fill_refused_alloc got=%0b exp=0", bus.res_valid); end
  endtask

  task automatic test_bypass();
    apply_reset();
    alloc(4'd5, BEQ, TI, 4'd9, 32'h40, 32'd0, 32'h500, 32'h8);
    bus.cdb_valid = 2'b01; bus.cdb_tag[0] = 4'd9; bus.cdb_val[0] = 32'h40;
    tick(); idle(); tick();
    n_checks++; if (bus.res_valid !== 1'b1 || bus.res_target !== 4'd5) begin n_fail++; $display("FAIL bypass_issue got=%0b/%h exp=1/5", bus.res_valid, bus.res_target); end
    n_checks++; if (bus.res_taken !== 1'b1 || bus.res_next_pc !== 32'h508) begin n_fail++; $display("FAIL bypass_value got=%0b/%h exp=1/00000508", bus.res_taken, bus.res_next_pc); end
  endtask

  task automatic test_flush();
    apply_reset();
    alloc(4'd3, BEQ, TI, TI, 32'd1, 32'd1, 32'h600, 32'h10); tick();
    alloc(4'd4, BEQ, TI, TI, 32'd2, 32'd2, 32'h700, 32'h10);
    bus.flush = 1'b1;
    tick(); idle();
    n_checks++; if (bus.res_valid !== 1'b0 || bus.res_target !== TI) begin n_fail++; $display("FAIL flush_result got=%0b/%h exp=0/f", bus.res_valid, bus.res_target); end
    tick(); tick();
    n_checks++; if (bus.res_valid !== 1'b0 || bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty got=%0b/%0b exp=0/1", bus.res_valid, bus.alloc_ready); end
  endtask

  task automatic test_random();
    m_ent_t      q[$];
    m_ent_t      e;
    int          idx;
    bit          ins, ev, etk;
    logic [3:0]  et;
    logic [31:0] enpc;
    apply_reset();
    etk = 1'b0; enpc = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      n_checks++; if (bus.alloc_ready !== (q.size() < DEPTH)) begin n_fail++; $display("FAIL rand_alloc_ready cyc=%0d got=%0b exp_count=%0d", cyc, bus.alloc_ready, q.size()); end
      bus.flush       = ($urandom_range(0, 29) == 0);
      bus.alloc_valid = ($urandom_range(0, 1) == 1);
      bus.alloc_target = 4'($urandom_range(0, 14));
      bus.alloc_op    = 3'($urandom_range(0, 7));
      bus.alloc_tag[0] = rand_tag(); bus.alloc_tag[1] = rand_tag();
      bus.alloc_val[0] = rand_val(); bus.alloc_val[1] = rand_val();
      bus.alloc_pc     = $urandom() & 32'hFFFF_FFFC;
      bus.alloc_offset = rand_val();
      for (int p = 0; p < CDB; p++) begin
        bus.cdb_valid[p] = ($urandom_range(0, 1) == 1);
        bus.cdb_tag[p]   = 4'($urandom_range(0, 15));
        bus.cdb_val[p]   = rand_val();
      end
      ev = 1'b0; et = TI;
      if (bus.flush) begin
        q.delete();
      end else begin
        ins = bus.alloc_valid && (q.size() < DEPTH);
        idx = -1;
        for (int i = 0; i < q.size(); i++) if (m_ready(q[i])) begin idx = i; break; end
        if (idx >= 0) begin
          ev = 1'b1; et = q[idx].target;
          m_resolve(q[idx], etk, enpc);
          q.delete(idx);
        end
        for (int i = 0; i < q.size(); i++) q[i] = m_wake(q[i]);
        if (ins) begin
          e.target = bus.alloc_target; e.op = bus.alloc_op;
          e.tag = bus.alloc_tag; e.val = bus.alloc_val;
          e.pc = bus.alloc_pc; e.off = bus.alloc_offset;
          q.push_back(m_wake(e));
        end
      end
      tick();
      n_checks++; if (bus.res_valid !== ev || bus.res_target !== et) begin n_fail++; $display("FAIL rand_issue cyc=%0d got=%0b/%h exp=%0b/%h", cyc, bus.res_valid, bus.res_target, ev, et); end
      if (ev) begin
        n_checks++; if (bus.res_taken !== etk || bus.res_next_pc !== enpc) begin n_fail++; $display("FAIL rand_resolve cyc=%0d got=%0b/%h exp=%0b/%h", cyc, bus.res_taken, bus.res_next_pc, etk, enpc); end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_beq();
    test_back_to_back_signed();
    test_fill_wakeup();
    test_bypass();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
